// File: rtl/laser_host_pkg.sv
// Shared types and constants for the laser host frame sequencer.
// Holds the FSM state encoding, default frame geometry and the squared-distance helper.
package laser_host_pkg;

  localparam int COORD_W       = 4;
  localparam int N_PTS_DEF     = 40;
  localparam int RADIUS_SQ_DEF = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SEND,
    WAIT_LOW,
    WAIT_HIGH,
    SCORE,
    REPORT
  } state_t;

  // Squared Euclidean distance; 9 bits holds 2*15^2 without wrap.
  function automatic logic [8:0] dist_sq(input coord_t ax, input coord_t ay,
                                         input coord_t bx, input coord_t by);
    coord_t     mx;
    coord_t     my;
    logic [7:0] sx;
    logic [7:0] sy;
    mx = (ax >= bx) ? (ax - bx) : (bx - ax);
    my = (ay >= by) ? (ay - by) : (by - ay);
    sx = {4'b0000, mx} * {4'b0000, mx};
    sy = {4'b0000, my} * {4'b0000, my};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational coverage test: is a point within the radius of either centre?
module laser_cover_chk
  import laser_host_pkg::*;
#(
  parameter int RADIUS_SQ = RADIUS_SQ_DEF
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] c1x,
  input  logic [COORD_W-1:0] c1y,
  input  logic [COORD_W-1:0] c2x,
  input  logic [COORD_W-1:0] c2y,
  output logic               covered
);

  localparam logic [8:0] R_SQ = 9'(RADIUS_SQ);

  assign covered = (dist_sq(px, py, c1x, c1y) <= R_SQ) ||
                   (dist_sq(px, py, c2x, c2y) <= R_SQ);

endmodule

// File: rtl/laser_host.sv
// Frame sequencer: buffers a point frame, streams it to the circle-search engine,
// captures the returned centres and scores how many points they cover.
module laser_host
  import laser_host_pkg::*;
#(
  parameter int N_PTS     = N_PTS_DEF,
  parameter int RADIUS_SQ = RADIUS_SQ_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_en,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               load_clr,
  input  logic               start,
  output logic               busy,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic               DONE,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  output logic               res_valid,
  output logic [COORD_W-1:0] res_c1x,
  output logic [COORD_W-1:0] res_c1y,
  output logic [COORD_W-1:0] res_c2x,
  output logic [COORD_W-1:0] res_c2y,
  output logic [5:0]         score
);

  localparam int PTR_W = $clog2(N_PTS + 1);
  localparam int CNT_W = $clog2(N_PTS);
  localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(N_PTS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N_PTS - 1);
  localparam logic [5:0]       SCORE_MAX = 6'(N_PTS);

  state_t                   state;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         cnt;
  logic [5:0]               acc;
  logic [2*COORD_W-1:0]     pt_mem [N_PTS];
  logic [2*COORD_W-1:0]     rd_pt;
  logic [CNT_W-1:0]         rd_idx;
  logic                     full;
  logic                     wr_en;
  logic                     covered;
  logic [5:0]               acc_next;

  assign full  = (wr_ptr == PTR_FULL);
  assign wr_en = (state == IDLE) && load_en && !load_clr && !full;
  assign busy  = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (wr_en) pt_mem[wr_ptr[CNT_W-1:0]] <= {load_x, load_y};
  end

  // During SEND the address runs one ahead so the output register holds point k in cycle k.
  always_comb begin
    rd_idx = cnt;
    if (state == SEND) begin
      rd_idx = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end else if (state != SCORE) begin
      rd_idx = '0;
    end
  end

  assign rd_pt = pt_mem[rd_idx];

  laser_cover_chk #(
    .RADIUS_SQ(RADIUS_SQ)
  ) u_cover_chk (
    .px     (rd_pt[2*COORD_W-1:COORD_W]),
    .py     (rd_pt[COORD_W-1:0]),
    .c1x    (res_c1x),
    .c1y    (res_c1y),
    .c2x    (res_c2x),
    .c2y    (res_c2y),
    .covered(covered)
  );

  assign acc_next = (covered && acc != SCORE_MAX) ? acc + 1'b1 : acc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      acc       <= '0;
      X         <= '0;
      Y         <= '0;
      res_valid <= 1'b0;
      res_c1x   <= '0;
      res_c1y   <= '0;
      res_c2x   <= '0;
      res_c2y   <= '0;
      score     <= '0;
    end else begin
      res_valid <= 1'b0;
      X         <= '0;
      Y         <= '0;
      case (state)
        IDLE: begin
          if (start && full) begin
            state <= WAIT_RDY;
          end else if (load_clr) begin
            wr_ptr <= '0;
          end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
        WAIT_RDY: begin
          if (DONE) begin
            state    <= SEND;
            cnt      <= '0;
            {X, Y}   <= rd_pt;
          end
        end
        SEND: begin
          if (cnt == CNT_LAST) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end else begin
            cnt    <= cnt + 1'b1;
            {X, Y} <= rd_pt;
          end
        end
        WAIT_LOW: begin
          if (!DONE) state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (DONE) begin
            res_c1x <= C1X;
            res_c1y <= C1Y;
            res_c2x <= C2X;
            res_c2y <= C2Y;
            cnt     <= '0;
            acc     <= '0;
            state   <= SCORE;
          end
        end
        SCORE: begin
          acc <= acc_next;
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            score     <= acc_next;
            res_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/laser_host.md
LASER_HOST -- requirements
Module: laser_host

Interface
REQ-001 SHALL have parameter N_PTS, default 40, meaning the number of points per frame.
REQ-002 SHALL have parameter RADIUS_SQ, default 16, meaning the coverage threshold on squared distance.
REQ-003 SHALL have ports as follows; one clock; reset is asynchronous and active-high.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- load_en  in  1  writes load_x/load_y into the point buffer.
- load_x, load_y  in  4 each  point coordinates to store.
- load_clr  in  1  empties the point buffer.
- start  in  1  requests one frame run.
- busy  out  1  high while not in IDLE.
- X, Y  out  4 each  point stream to the circle-search engine.
- DONE  in  1  engine ready/finished flag.
- C1X, C1Y, C2X, C2Y  in  4 each  engine result centres.
- res_valid  out  1  one-cycle result strobe.
- res_c1x, res_c1y, res_c2x, res_c2y  out  4 each  captured centres.
- score  out  6  count of covered points.

Function
REQ-004 SHALL hold a buffer of N_PTS points and a write pointer wr_ptr (0..N_PTS).
REQ-005 SHALL accept load_en only in IDLE with wr_ptr<N_PTS: store at wr_ptr, then wr_ptr+1.
REQ-006 SHALL silently drop load_en when the buffer is full or the block is not in IDLE.
REQ-007 SHALL set wr_ptr=0 on load_clr in IDLE; if load_clr and load_en coincide, load_clr wins.
REQ-008 SHALL run the state machine IDLE -> WAIT_RDY -> SEND -> WAIT_LOW -> WAIT_HIGH -> SCORE -> REPORT -> IDLE.
REQ-009 IDLE SHALL move to WAIT_RDY on start only when wr_ptr==N_PTS; start is otherwise ignored.
REQ-010 WAIT_RDY SHALL move to SEND in the cycle after DONE is sampled high.
REQ-011 SEND SHALL last exactly N_PTS cycles, with registered X/Y equal to point k in the k-th SEND cycle (k=0..N_PTS-1).
REQ-012 X/Y SHALL be 0 in every state other than SEND.
REQ-013 WAIT_LOW SHALL wait for DONE==0; WAIT_HIGH SHALL wait for DONE==1.
REQ-014 On exit from WAIT_HIGH, C1X..C2Y SHALL be captured into res_c*.
REQ-015 SCORE SHALL take N_PTS cycles, examining one point per cycle.
REQ-016 In SCORE, a point SHALL count once if (dx^2+dy^2)<=RADIUS_SQ for either C1 or C2.
- dx, dy are 5-bit signed differences; squares are 8-bit unsigned; the sum is 9-bit, with no wrap.
REQ-017 score SHALL saturate at N_PTS, which fits in 6 bits.
REQ-018 REPORT SHALL assert res_valid for exactly one cycle with score and res_c* stable.
- score and res_c* hold their values until the next REPORT.
REQ-019 The buffer SHALL be retained after REPORT, so a new start re-runs the same frame without reloading.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 start and load_en SHALL be ignored while busy.

Reset
REQ-022 RST SHALL force the following, effective immediately, including mid-SEND or mid-SCORE:
- state IDLE; wr_ptr 0; X, Y 0.
- res_valid 0; res_c* 0; score 0; busy 0.
REQ-023 Buffer contents SHALL NOT require reset; they are unreadable until reloaded.

Structure
REQ-024 A shared package SHALL hold the state enum, N_PTS, RADIUS_SQ, and the coordinate width 4.
REQ-025 One sub-module, laser_cover_chk, SHALL be used: a combinational point-vs-two-centres test returning a 1-bit covered flag.

Verification
REQ-026 The bench SHALL cover at least the following directed scenarios:
- Load 40 points (k,k mod 16 pattern), start with DONE=1 -> X/Y show pts 0..39 on 40 consecutive cycles after WAIT_RDY; busy=1.
- Engine model drops DONE 5 cycles after SEND and raises it 20 cycles later, C1=(3,3), C2=(12,12), all 40 points at (3,3) -> res_valid one cycle, score=40, res_c1=(3,3).
- Points at (7,3) and (8,3) with C1=(3,3), C2=(15,15) -> (7,3) counted (16<=16) and (8,3) not counted (25).
- start with only 39 points loaded -> stays IDLE; the 41st load_en is dropped and wr_ptr stays 40.
- RST asserted in SEND cycle 20 -> X/Y=0, busy=0 and IDLE next edge; a following start re-sends from pt 0.
- load_clr and load_en in the same cycle -> wr_ptr=0, with no write.
